// File: rtl/sin_sweep.sv
// sin_sweep: drives the iterative sin core through a sweep of cfg_count angles and streams (angle, sin) beats.
module sin_sweep #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_i,
  input  logic [15:0] cfg_start_i,
  input  logic [15:0] cfg_step_i,
  input  logic [7:0]  cfg_count_i,
  output logic [15:0] sin_x_o,
  output logic        sin_start_o,
  input  logic [15:0] sin_result_i,
  input  logic        sin_done_i,
  output logic [15:0] out_x_o,
  output logic [15:0] out_data_o,
  output logic        out_last_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        sweep_done_o,
  output logic        timeout_err_o
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;
  state_t        state_q;
  logic [15:0]   x_q, step_q, sin_x_q, out_x_q, out_data_q, x_inc;
  logic [7:0]    rem_q;
  logic [TW-1:0] tmr_q;
  logic          sin_start_q, out_last_q, out_valid_q, busy_q, sweep_done_q, timeout_err_q;
  assign x_inc = x_q + step_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      step_q        <= '0;
      rem_q         <= '0;
      tmr_q         <= '0;
      sin_x_q       <= '0;
      out_x_q       <= '0;
      out_data_q    <= '0;
      sin_start_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sin_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: if (go_i) begin
          timeout_err_q <= 1'b0;
          if (cfg_count_i == 8'd0) sweep_done_q <= 1'b1;
          else begin
            x_q         <= cfg_start_i;
            step_q      <= cfg_step_i;
            rem_q       <= cfg_count_i;
            sin_x_q     <= cfg_start_i;
            sin_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          tmr_q   <= '0;
          state_q <= WAIT;
        end
        // a done arriving in the expiry cycle still produces a beat
        WAIT: if (sin_done_i) begin
          out_data_q  <= sin_result_i;
          out_x_q     <= x_q;
          out_last_q  <= rem_q == 8'd1;
          out_valid_q <= 1'b1;
          state_q     <= PUSH;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          timeout_err_q <= 1'b1;
          sweep_done_q  <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end else tmr_q <= tmr_q + 1'b1;
        PUSH: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          rem_q       <= rem_q - 8'd1;
          x_q         <= x_inc;
          if (out_last_q) begin
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            sin_x_q     <= x_inc;
            sin_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sin_x_o       = sin_x_q;
  assign sin_start_o   = sin_start_q;
  assign out_x_o       = out_x_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;
  assign out_valid_o   = out_valid_q;
  assign busy_o        = busy_q;
  assign sweep_done_o  = sweep_done_q;
  assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_sin_sweep.sv
// tb_sin_sweep: randomized sweeps against a sin core model and a beat-list reference of the sweep.
module tb_sin_sweep;
  localparam int TO = 64;
  typedef struct {logic [15:0] x; logic [15:0] d; logic l;} beat_t;
  logic clk = 0, rst = 1, go = 0, out_ready = 1, sin_done = 0, spur_done = 0;
  logic [15:0] cfg_start = 0, cfg_step = 0, sin_result = 0;
  logic [7:0] cfg_count = 0;
  logic [15:0] sin_x, out_x, out_data;
  logic sin_start, out_last, out_valid, busy, sweep_done, timeout_err;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int core_lat = 1, stall_b = -1, stall_left = 0, go_cyc = 0, cnt_g = 0;
  bit spur = 0, exp_to_g = 0;
  int n_start = 0, n_beat = 0, n_sd = 0, overlap = 0, unstable = 0, last_start = 0, last_hs = 0;
  beat_t exp_q[$];
  logic [15:0] xq[$];
  sin_sweep #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go_i(go), .cfg_start_i(cfg_start), .cfg_step_i(cfg_step),
    .cfg_count_i(cfg_count), .sin_x_o(sin_x), .sin_start_o(sin_start),
    .sin_result_i(sin_result), .sin_done_i(sin_done | spur_done), .out_x_o(out_x),
    .out_data_o(out_data), .out_last_o(out_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy), .sweep_done_o(sweep_done),
    .timeout_err_o(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] ref_sin(input logic [15:0] x);
    return (x == 16'h4000) ? 16'h3D5E : 16'(x * 16'd3 + 16'h1234);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // sin core model: answers each start after core_lat cycles; core_lat 0 means it hangs
  initial begin
    logic [15:0] cx;
    forever begin
      @(negedge clk);
      if (!rst && sin_start && core_lat > 0) begin
        cx = sin_x;
        repeat (core_lat) @(posedge clk);
        #1 sin_done = 1; sin_result = ref_sin(cx);
        @(posedge clk); #1 sin_done = 0;
        if (spur) begin
          repeat (2) @(posedge clk);
          #1 spur_done = 1; sin_result = 16'hDEAD;
          @(posedge clk); #1 spur_done = 0;
        end
      end
    end
  end
  initial forever begin
    @(posedge clk); #1;
    out_ready = !(out_valid && n_beat == stall_b && stall_left > 0);
    if (!out_ready) stall_left--;
  end
  initial begin
    beat_t b;
    logic pv, phs, pl;
    logic [15:0] px, pd;
    pv = 0; phs = 0; pl = 0; px = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (rst) pv = 0;
      else begin
        if (sin_start) begin
          n_start++;
          if (xq.size() > 0) chk("sin_x", sin_x, xq.pop_front()); else chk("extra_start", 1, 0);
          if (n_start == 1) chk("go_to_start", cyc - go_cyc, 1); else chk("hs_to_start", cyc - last_hs, 1);
          last_start = cyc;
          if (out_valid) overlap++;
        end
        if (out_valid && !pv) chk("start_to_valid", cyc - last_start, core_lat + 1);
        if (pv && !phs && (!out_valid || out_x !== px || out_data !== pd || out_last !== pl)) unstable++;
        if (out_valid && out_ready) begin
          n_beat++;
          last_hs = cyc;
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            b = exp_q.pop_front();
            chk("out_x", out_x, b.x);
            chk("out_data", out_data, b.d);
            chk("out_last", out_last, b.l);
          end
        end
        if (sweep_done) begin
          n_sd++;
          chk("busy_at_done", busy, 0);
          if (exp_to_g) chk("timeout_latency", cyc - last_start, TO + 1);
          else if (cnt_g == 0) chk("zero_done", cyc - go_cyc, 1);
          else chk("hs_to_done", cyc - last_hs, 1);
        end
        pv = out_valid; phs = out_valid && out_ready; px = out_x; pd = out_data; pl = out_last;
      end
    end
  end
  task automatic start_sweep(input logic [15:0] st, input logic [15:0] sp, input logic [7:0] n,
                             input int lat, input int sb, input int sn, input bit sp_en);
    beat_t b;
    exp_q.delete(); xq.delete();
    core_lat = lat; spur = sp_en; stall_b = sb; stall_left = sn; cnt_g = n;
    exp_to_g = (n != 0) && (lat == 0 || lat > TO);
    for (int i = 0; i < int'(n); i++) begin
      b.x = 16'(st + i * sp); b.d = ref_sin(b.x); b.l = (i == int'(n) - 1);
      if (!exp_to_g || i == 0) xq.push_back(b.x);
      if (!exp_to_g) exp_q.push_back(b);
    end
    n_start = 0; n_beat = 0; n_sd = 0; overlap = 0; unstable = 0;
    cfg_start = st; cfg_step = sp; cfg_count = n; go = 1; go_cyc = cyc;
    @(posedge clk); #1 go = 0;
    chk("busy_after_go", busy, n != 0);
    chk("terr_cleared", timeout_err, 0);
  endtask
  task automatic run_sweep(input logic [15:0] st, input logic [15:0] sp, input logic [7:0] n,
                           input int lat, input int sb, input int sn, input bit go_mid, input bit sp_en);
    int k;
    start_sweep(st, sp, n, lat, sb, sn, sp_en);
    k = 0;
    while (n_sd == 0 && k < 3000) begin
      @(posedge clk); #1 k++;
      if (go_mid && k == 8) begin cfg_count = 8'd9; go = 1; end else go = 0;
    end
    go = 0;
    chk("sweep_finished", n_sd > 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", n_sd, 1);
    chk("starts", n_start, exp_to_g ? 1 : int'(n));
    chk("beats", n_beat, exp_to_g ? 0 : int'(n));
    chk("timeout_err", timeout_err, exp_to_g);
    chk("no_overlap", overlap, 0);
    chk("hold_stable", unstable, 0);
  endtask
  task automatic rst_mid(input int lat, input int sb, input int sn, input bit in_push);
    start_sweep(16'h2222, 16'h0001, 8'd4, lat, sb, sn, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", out_valid, in_push);
    #3 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", sin_start, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_out_x", out_x, 0);
    chk("arst_sweep_done", sweep_done, 0);
    chk("arst_terr", timeout_err, 0);
    @(posedge clk); #1 rst = 0;
    stall_left = 0;
    repeat (70) @(posedge clk);
    #1;
    chk("rst_no_sweep_done", n_sd, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_start", sin_start, 0);
    chk("reset_sin_x", sin_x, 0);
    rst = 0;
    @(posedge clk); #1;
    run_sweep(16'h4000, 16'h0000, 8'd1, 16, -1, 0, 0, 0);
    run_sweep(16'h0000, 16'h2000, 8'd3, 5, 1, 5, 0, 0);
    run_sweep(16'h7000, 16'h2000, 8'd2, 3, -1, 0, 0, 0);
    run_sweep(16'h1000, 16'h0100, 8'd3, 0, -1, 0, 0, 0);
    run_sweep(16'h1234, 16'h0010, 8'd2, TO, -1, 0, 0, 0);
    run_sweep(16'h0ABC, 16'h0010, 8'd2, TO + 1, -1, 0, 0, 0);
    run_sweep(16'h5555, 16'h0001, 8'd0, 3, -1, 0, 0, 0);
    run_sweep(16'hF000, 16'h0800, 8'd3, 20, -1, 0, 1, 0);
    run_sweep(16'h0100, 16'h0100, 8'd2, 4, 0, 6, 0, 1);
    rst_mid(0, -1, 0, 0);
    rst_mid(2, 0, 30, 1);
    run_sweep(16'h3000, 16'hF000, 8'd3, 2, -1, 0, 0, 0);
    for (int r = 0; r < 8; r++)
      run_sweep(16'($urandom), 16'($urandom), 8'($urandom_range(1, 6)), int'($urandom_range(1, 20)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sin_sweep.md
# sin_sweep

Request-side sequencer for the iterative `sin` unit. It turns a single `go` into a sweep of `cfg_count` angles: `cfg_start`, `cfg_start+cfg_step`, and so on. For each angle it drives the unit's `x`/`start` inputs, waits for `done`, and presents each (angle, result) pair on a valid/ready output stream. It sits between the control/register logic and the `sin` core, and guards against a hung core with a timeout.

## Interface
- `TIMEOUT`, 64: max cycles from `sin_start` to `sin_done` before abort; must be ≥2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: sweep request, sampled only in IDLE.
- `cfg_start` in 16: first angle, signed Q1.15 (0x4000 = 0.5).
- `cfg_step` in 16: angle increment, signed Q1.15.
- `cfg_count` in 8: number of points, 0–255.
- `sin_x` out 16: angle to `sin` core.
- `sin_start` out 1: one-cycle start pulse to core.
- `sin_result` in 16: core result, Q1.15.
- `sin_done` in 1: core completion pulse.
- `out_x` out 16: angle of the presented point.
- `out_data` out 16: sine of `out_x`.
- `out_last` out 1: the presented point is the final point.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `busy` out 1: high whenever the state is not IDLE.
- `sweep_done` out 1: one-cycle pulse at the end of a sweep, normal or aborted.
- `timeout_err` out 1: sticky abort flag; cleared when the next `go` is accepted.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE; the angle register and the remaining-count register reset to 0.
- States: IDLE, ISSUE, WAIT, PUSH.
- IDLE, `go`=1, `cfg_count`≠0:
  - latch `cfg_start` into x_reg, `cfg_step` into step_reg, `cfg_count` into rem;
  - clear `timeout_err`;
  - next state ISSUE.
- IDLE, `go`=1, `cfg_count`=0: pulse `sweep_done` next cycle, clear `timeout_err`, stay in IDLE; no `sin_start`.
- ISSUE:
  - `sin_start`=1 for exactly this cycle;
  - `sin_x`=x_reg, held stable through WAIT;
  - timer cleared; next state WAIT.
- WAIT:
  - on `sin_done`=1: out_data←`sin_result`, out_x←x_reg, out_last←(rem==1), out_valid←1; next state PUSH.
  - timer increments each WAIT cycle. If it reaches TIMEOUT−1 with no `sin_done`: `timeout_err`←1, `sweep_done` pulse, next state IDLE, no output beat.
  - if `sin_done` arrives in the same cycle the timer expires, `sin_done` wins.
- PUSH:
  - `out_valid`, `out_x`, `out_data`, `out_last` held stable until `out_ready`=1.
  - on handshake: out_valid←0, rem←rem−1, x_reg←x_reg+step_reg.
  - if the beat was last: IDLE with a `sweep_done` pulse; otherwise ISSUE.
- Angle arithmetic is 16-bit two's-complement wrap-around; there is no saturation (0x7000+0x2000 = 0x9000).
- `go` is ignored while `busy`. `sin_done` is ignored outside WAIT. `out_ready` is ignored outside PUSH.
- Asserting `rst` mid-sweep aborts at once: outputs go to 0 asynchronously, no `sweep_done` pulse, no partial beat.

## Timing
- `go` is sampled at edge e. `busy`=1 and `sin_start`=1 during the cycle after e.
- With `sin_start` high in cycle t and `sin_done` high in cycle t+L:
  - `out_valid` rises in cycle t+L+1;
  - with `out_ready` held high, the next `sin_start` is in cycle t+L+2, so the point period is L+2 cycles.
- Output stall: each extra cycle of `out_ready`=0 delays the next `sin_start` by one cycle. There is never more than one request in flight.
- `sweep_done` is high in the first IDLE cycle after the final handshake or the timeout. `busy` is 0 in that same cycle.
- Timeout: the abort is taken TIMEOUT cycles after the ISSUE cycle.

## Test plan
- Reset: assert `rst` while in WAIT.
  - Expected: `sin_start`, `out_valid`, `busy`, `sweep_done` and `timeout_err` drop to 0 without waiting for a clock edge.
  - After `rst` deasserts: FSM in IDLE; a new `go` starts normally.
- Single point: `cfg_start`=0x4000, `cfg_step`=0, `cfg_count`=1, core model latency 16 returning 0x3D5E.
  - Expected: one `sin_start` with `sin_x`=0x4000; then `out_x`=0x4000, `out_data`=0x3D5E, `out_last`=1.
  - `sweep_done` pulses the cycle after the handshake.
- Three points with stall: `cfg_start`=0x0000, `cfg_step`=0x2000, `cfg_count`=3; `out_ready` low for 5 cycles on beat 2.
  - Expected: `sin_x` sequence 0x0000, 0x2000, 0x4000.
  - No `sin_start` until beat 2 is accepted; beat 2 data held stable throughout the stall.
  - Only beat 3 has `out_last`=1.
- Wrap-around: `cfg_start`=0x7000, `cfg_step`=0x2000, `cfg_count`=2.
  - Expected: second `sin_x`=0x9000.
- Timeout: core model never asserts `sin_done`, TIMEOUT=64.
  - Expected: `timeout_err`=1, one `sweep_done` pulse, `busy`=0, no `out_valid`.
  - The next accepted `go` clears `timeout_err`.
  - Variant: `sin_done` in the expiry cycle gives a normal output beat and no error.
- Degenerate and ignored inputs:
  - `cfg_count`=0 gives a `sweep_done` pulse and no `sin_start`.
  - `go` pulsed mid-sweep has no effect on the point count.
  - A spurious `sin_done` while in PUSH has no effect.
